ppm_cs_resolver: RTL
====================

Name: ppm_cs_resolver

Overview:
- Consumes the redundant carry-save pair (out1, out2) produced by the PPM partial-product multiplier and resolves it into the final binary product.
- Resolution is multi-cycle: one CHUNK-bit slice is added per clock, with a registered carry between slices. This keeps the wide carry-propagate adder off the critical path.
- Sits directly downstream of PPM and uses a valid/ready handshake on both sides.

Parameters:
- N, 8, width of multiplicand a feeding the upstream PPM.
- M, 8, width of multiplier b feeding the upstream PPM.
- CHUNK, 4, bits resolved per cycle; legal range 1..N+M.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  carry-save pair is present on in1/in2.
- in_ready  output  1  block can accept a pair.
- in1  input  N+M  first carry-save word (PPM out1).
- in2  input  N+M  second carry-save word (PPM out2).
- out_valid  output  1  sum is valid.
- out_ready  input  1  downstream accepts sum.
- sum  output  N+M  (in1 + in2) mod 2^(N+M).

Behaviour:
- Definitions: W = N+M; NCH = ceil(W/CHUNK).
- States:
  - IDLE: in_ready=1, out_valid=0.
  - ADD: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (async assert, sync deassert handled upstream) forces state IDLE. It also forces sum=0, out_valid=0, carry register=0, slice index=0. in_ready=1 after reset.
- IDLE to ADD: on the edge where in_valid & in_ready.
  - Capture in1 and in2 into operand registers.
  - Clear the carry and the slice index.
- ADD, each edge:
  - Add slice k of both operands plus the carry.
  - Write the CHUNK result bits into bits [k*CHUNK +: CHUNK] of the sum register; store the carry-out; k increments.
  - After the edge where k = NCH-1, go to DONE.
- Latency: out_valid rises exactly NCH clock edges after the accept edge (8x8, CHUNK=4: 4 cycles).
- Partial last slice (W not a multiple of CHUNK):
  - Operand bits above W-1 are treated as 0.
  - Result bits above W-1 are discarded.
  - The carry out of bit W-1 is the final carry.
- DONE:
  - sum is held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE. sum keeps its value; out_valid drops.
- in_ready=0 in ADD and DONE, so no overlap. Max throughput is one result per NCH+2 cycles.
- Input changes while not in IDLE are ignored, because the operands are registered.
- sum is modular: the carry beyond bit W-1 is dropped unless the optional feature below is enabled.
- Arithmetic is signedness-agnostic. Two's-complement products resolve correctly mod 2^W.
- Reset mid-ADD or mid-DONE aborts immediately. The partial result is lost and the block returns to IDLE.

Optional Feature:
- Macro: PPM_CARRY_OUT_EN.
- Defined: adds an output port sum_cout (1 bit).
  - Carries the final carry out of bit W-1.
  - Valid with out_valid and held with sum; reset value 0.
- Undefined: the port does not exist and the final carry is discarded.

Decomposition:
- Package ppm_pkg holds:
  - the state encoding typedef (IDLE, ADD, DONE);
  - a function computing NCH from W and CHUNK;
  - the slice-index width localparam function (clog2 of NCH, minimum 1).
- Sub-module ppm_chunk_adder:
  - Purely combinational, parameter CHUNK.
  - Inputs: a, b, cin. Outputs: s, cout.
  - Instantiated once and reused each cycle via slice muxing.

Test Plan:
- Basic, N=M=8, CHUNK=4:
  - Stimulus: in1=16'h1234, in2=16'h0FF0.
  - Response: out_valid 4 cycles after accept; sum=16'h2224; in_ready=0 throughout ADD/DONE.
- Wrap-around carry chain:
  - Stimulus: in1=16'hFFFF, in2=16'h0001.
  - Response: sum=16'h0000, with carry rippling through all 4 slices.
  - With PPM_CARRY_OUT_EN: sum_cout=1.
- Backpressure:
  - Stimulus: out_ready held 0 for 5 cycles after out_valid.
  - Response: sum stays 16'h2224 and out_valid stays 1. On out_ready=1, return to IDLE next edge and in_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously 2 cycles into ADD.
  - Response: out_valid=0, sum=0, in_ready=1 immediately, with no clock edge needed.
  - A new pair (16'h00FF + 16'h0001) then yields 16'h0100.
- Partial slice, N=5, M=5, CHUNK=4 (W=10, NCH=3):
  - Stimulus: in1=10'h3FF, in2=10'h001.
  - Response: sum=10'h000 after 3 cycles; cout=1 when the feature is enabled.
- End-to-end with PPM:
  - Stimulus: 50 random signed and unsigned a,b pairs through PPM into this block.
  - Response: sum == (a*b) mod 2^W for every pair.

Source files
------------

// File: rtl/ppm_cs_resolver_pkg.sv
// ============================================================================
// Module : ppm_pkg
// Brief  : Shared types and sizing helpers for the PPM carry-save resolver.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppm_pkg;

    // Resolver control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } ppm_state_t;

    // Number of CHUNK-wide slices needed to cover a W-bit word
    function automatic int ppm_nch(input int w, input int chunk);
        return (w + chunk - 1) / chunk;
    endfunction

    // Width of the slice index register (never narrower than one bit)
    function automatic int ppm_idx_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ppm_cs_resolver_chunk_adder.sv
// ============================================================================
// Module : ppm_chunk_adder
// Brief  : Combinational CHUNK-bit adder with carry in/out; one slice of the
//          multi-cycle carry-propagate resolution.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppm_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] w_full;

    // Zero-extend by one bit so the carry lands in the MSB
    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s      = w_full[CHUNK-1:0];
    assign cout   = w_full[CHUNK];

endmodule

`default_nettype wire

// File: rtl/ppm_cs_resolver.sv
// ============================================================================
// Module : ppm_cs_resolver
// Brief  : Resolves the PPM carry-save pair (in1, in2) into a binary sum,
//          one CHUNK-bit slice per clock with a registered inter-slice carry.
//          Optional macro PPM_CARRY_OUT_EN adds the sum_cout output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppm_cs_resolver
    import ppm_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N+M-1:0] in1,
    input  logic [N+M-1:0] in2,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef PPM_CARRY_OUT_EN
    output logic           sum_cout,
`endif
    output logic [N+M-1:0] sum
);

    localparam int W     = N + M;
    localparam int NCH   = ppm_nch(W, CHUNK);
    localparam int IW    = ppm_idx_w(NCH);
    // Position of the carry out of bit W-1 inside the last slice's result
    localparam int LASTB = W - (NCH - 1) * CHUNK;

    ppm_state_t      state_q,     state_d;
    logic [W-1:0]    op1_q,       op1_d;
    logic [W-1:0]    op2_q,       op2_d;
    logic [W-1:0]    sum_q,       sum_d;
    logic [IW-1:0]   idx_q,       idx_d;
    logic            carry_q,     carry_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
`ifdef PPM_CARRY_OUT_EN
    logic            cout_q,      cout_d;
    logic [CHUNK:0]  w_full;
`endif

    int              w_sh;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;

    // Right shift zero-fills, so operand bits above W-1 read as 0
    assign w_sh = int'(idx_q) * CHUNK;
    assign w_a  = CHUNK'(op1_q >> w_sh);
    assign w_b  = CHUNK'(op2_q >> w_sh);

    ppm_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (w_a),
        .b    (w_b),
        .cin  (carry_q),
        .s    (w_s),
        .cout (w_cout)
    );

`ifdef PPM_CARRY_OUT_EN
    assign w_full = {w_cout, w_s};
`endif

    // Next-state, slice write-back and handshake decode
    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef PPM_CARRY_OUT_EN
        cout_d      = cout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_ADD;
                    op1_d      = in1;
                    op2_d      = in2;
                    carry_d    = 1'b0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                end
            end
            ST_ADD: begin
                // Result bits shifted past W-1 fall off the top
                sum_d   = (sum_q & ~(W'({CHUNK{1'b1}}) << w_sh)) | (W'(w_s) << w_sh);
                carry_d = w_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NCH - 1)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
`ifdef PPM_CARRY_OUT_EN
                    cout_d      = w_full[LASTB];
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef PPM_CARRY_OUT_EN
            cout_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef PPM_CARRY_OUT_EN
            cout_q      <= cout_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
`ifdef PPM_CARRY_OUT_EN
    assign sum_cout  = cout_q;
`endif

endmodule

`default_nettype wire
